// File: rtl/soc_system_led_pio.sv
// rtl/soc_system_led_pio.sv - Avalon-MM LED output PIO with set/clear aliases and optional blink engine
// Optional feature macro: LED_PIO_BLINK_EN (blink mask/period/status registers and blink counter)
module soc_system_led_pio #(
  parameter int          WIDTH       = 10,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          DIV_W       = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic             wr_en;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      rd_next;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wr_bits   = writedata[WIDTH-1:0];
  // upper writedata bits are deliberately dropped by every register
  assign unused_wd = ^writedata;

  // DATA register: direct write plus bit-set and bit-clear aliases
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE[WIDTH-1:0];
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_q <= wr_bits;
        ADDR_OUTSET:   data_q <= data_q | wr_bits;
        ADDR_OUTCLEAR: data_q <= data_q & ~wr_bits;
        default:       data_q <= data_q;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0] mask_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt_q;
  logic             phase_q;

  // BLINK_MASK register
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (wr_en && address == ADDR_MASK) begin
      mask_q <= wr_bits;
    end
  end

  // blink period register and counter; a period write restarts the cycle and beats a terminal-count toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else if (wr_en && address == ADDR_PERIOD) begin
      period_q <= writedata[DIV_W-1:0];
      cnt_q    <= writedata[DIV_W-1:0];
      phase_q  <= 1'b0;
    end else if (period_q == '0) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q    <= period_q;
      phase_q  <= ~phase_q;
    end else begin
      cnt_q    <= cnt_q - DIV_W'(1);
    end
  end

  // read mux over the current (pre-edge) register contents
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next[WIDTH-1:0] = data_q;
      ADDR_MASK:   rd_next[WIDTH-1:0] = mask_q;
      ADDR_PERIOD: rd_next[DIV_W-1:0] = period_q;
      ADDR_STATUS: rd_next[0]         = phase_q;
      default:     rd_next            = '0;
    endcase
  end

  assign out_port = data_q & ~(mask_q & {WIDTH{phase_q}});
`else
  // read mux: only DATA is readable when the blink engine is not built
  always_comb begin
    rd_next = '0;
    if (address == ADDR_DATA) begin
      rd_next[WIDTH-1:0] = data_q;
    end
  end

  assign out_port = data_q;
`endif

  // registered read data, refreshed every cycle with no read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_soc_system_led_pio.sv
// tb/tb_soc_system_led_pio.sv - scoreboard bench for soc_system_led_pio (follows LED_PIO_BLINK_EN if defined)
module tb_soc_system_led_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          ck_rd;
    logic [31:0] rd;
    bit          ck_out;
    logic [9:0]  outv;
    string       nm;
  } exp_t;

  exp_t q[$];

  soc_system_led_pio #(
    .WIDTH(10),
    .RESET_VALUE(32'h155),
    .DIV_W(26)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs and queue the outputs expected right after the coming edge
  task automatic step(input logic rst, input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] wd, input bit ckr, input logic [31:0] erd,
                      input bit cko, input logic [9:0] eout, input string nm);
    exp_t e;
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    e.ck_rd  = ckr;
    e.rd     = erd;
    e.ck_out = cko;
    e.outv   = eout;
    e.nm     = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // monitor: pops one expectation per edge and compares away from the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.ck_rd) begin
          total++;
          if (readdata !== e.rd) begin
            bad++;
            $display("FAIL %s readdata actual=%h required=%h", e.nm, readdata, e.rd);
          end
        end
        if (e.ck_out) begin
          total++;
          if (out_port !== e.outv) begin
            bad++;
            $display("FAIL %s out_port actual=%h required=%h", e.nm, out_port, e.outv);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and reset-value readback
    step(1, 0, 1, 3'd0, 32'h0, 1, 32'h0, 1, 10'h155, "reset0");
    step(1, 1, 0, 3'd0, 32'h0, 1, 32'h0, 1, 10'h155, "reset_wr");
    step(0, 0, 1, 3'd0, 32'h0, 1, 32'h155, 1, 10'h155, "rst_rd0");
    step(0, 0, 1, 3'd1, 32'h0, 1, 32'h0, 1, 10'h155, "rst_rd1");
    step(0, 0, 1, 3'd2, 32'h0, 1, 32'h0, 1, 10'h155, "rst_rd2");
    step(0, 0, 1, 3'd3, 32'h0, 1, 32'h0, 1, 10'h155, "rst_rd3");

    // DATA / OUTSET / OUTCLEAR on consecutive cycles
    step(0, 1, 0, 3'd0, 32'hFFFF_F0F0, 1, 32'h155, 1, 10'h0F0, "wr_data");
    step(0, 1, 0, 3'd4, 32'h0000_0003, 1, 32'h0, 1, 10'h0F3, "outset");
    step(0, 1, 0, 3'd5, 32'h0000_0030, 1, 32'h0, 1, 10'h0C3, "outclear");
    step(0, 0, 1, 3'd0, 32'h0, 1, 32'h0C3, 1, 10'h0C3, "rd_data");
    step(0, 0, 0, 3'd0, 32'h0, 1, 32'h0C3, 1, 10'h0C3, "no_cs");
    step(0, 1, 1, 3'd0, 32'h0, 1, 32'h0C3, 1, 10'h0C3, "no_wr_n");
    step(0, 1, 0, 3'd6, 32'h3FF, 1, 32'h0, 1, 10'h0C3, "wr_addr6");
    step(0, 0, 1, 3'd7, 32'h0, 1, 32'h0, 1, 10'h0C3, "rd_addr7");
    step(0, 0, 1, 3'd4, 32'h0, 1, 32'h0, 1, 10'h0C3, "rd_addr4");
    step(0, 0, 1, 3'd5, 32'h0, 1, 32'h0, 1, 10'h0C3, "rd_addr5");

`ifdef LED_PIO_BLINK_EN
    step(0, 1, 0, 3'd0, 32'h3FF, 1, 32'h0C3, 1, 10'h3FF, "bl_data");
    step(0, 1, 0, 3'd1, 32'hFFFF_FC01, 1, 32'h0, 1, 10'h3FF, "bl_mask");
    step(0, 0, 1, 3'd1, 32'h0, 1, 32'h001, 1, 10'h3FF, "bl_rdmask");
    step(0, 1, 0, 3'd2, 32'h3, 1, 32'h0, 1, 10'h3FF, "bl_per3");
    // edges 1..11 after the period write: phase high after edges 4..7
    for (int k = 1; k <= 11; k++) begin
      step(0, 0, 1, 3'd3, 32'h0, 1, ((k - 1) >= 4 && (k - 1) <= 7) ? 32'h1 : 32'h0,
           1, (k >= 4 && k <= 7) ? 10'h3FE : 10'h3FF, "bl_p3");
    end
    // edge 12 would toggle (cnt==0); the period write wins
    step(0, 1, 0, 3'd2, 32'h5, 1, 32'h3, 1, 10'h3FF, "bl_per5");
    for (int k = 13; k <= 18; k++) begin
      step(0, 0, 1, 3'd3, 32'h0, 1, 32'h0, 1, (k == 18) ? 10'h3FE : 10'h3FF, "bl_p5");
    end
    step(0, 1, 0, 3'd2, 32'h0, 1, 32'h5, 1, 10'h3FF, "bl_per0");
    step(0, 0, 1, 3'd3, 32'h0, 1, 32'h0, 1, 10'h3FF, "bl_stat0");
    step(0, 0, 1, 3'd2, 32'h0, 1, 32'h0, 1, 10'h3FF, "bl_rdper0");
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 3'd0, 32'h0, 1, 32'h3FF, 1, 10'h3FF, "bl_idle");
    end
    // restart a fast blink so reset lands mid-blink
    step(0, 1, 0, 3'd2, 32'h1, 1, 32'h0, 1, 10'h3FF, "bl_per1");
    step(0, 0, 1, 3'd0, 32'h0, 1, 32'h3FF, 1, 10'h3FF, "bl_p1a");
    step(0, 0, 1, 3'd0, 32'h0, 1, 32'h3FF, 1, 10'h3FE, "bl_p1b");
`else
    step(0, 1, 0, 3'd1, 32'h3FF, 1, 32'h0, 1, 10'h0C3, "nb_wrmask");
    step(0, 1, 0, 3'd2, 32'h3, 1, 32'h0, 1, 10'h0C3, "nb_wrper");
    step(0, 0, 1, 3'd1, 32'h0, 1, 32'h0, 1, 10'h0C3, "nb_rd1");
    step(0, 0, 1, 3'd2, 32'h0, 1, 32'h0, 1, 10'h0C3, "nb_rd2");
    step(0, 0, 1, 3'd3, 32'h0, 1, 32'h0, 1, 10'h0C3, "nb_rd3");
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 3'd0, 32'h0, 1, 32'h0C3, 1, 10'h0C3, "nb_idle");
    end
`endif

    // reset with a coincident DATA write: reset wins
    step(1, 1, 0, 3'd0, 32'h0, 1, 32'h0, 1, 10'h155, "mid_reset");
    step(0, 0, 1, 3'd0, 32'h0, 1, 32'h155, 1, 10'h155, "post_rd0");
    step(0, 0, 1, 3'd1, 32'h0, 1, 32'h0, 1, 10'h155, "post_rd1");
    step(0, 0, 1, 3'd2, 32'h0, 1, 32'h0, 1, 10'h155, "post_rd2");
    step(0, 0, 1, 3'd3, 32'h0, 1, 32'h0, 1, 10'h155, "post_rd3");
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 3'd0, 32'h0, 1, 32'h155, 1, 10'h155, "post_idle");
    end

    repeat (2) @(posedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain queue_left actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
